avalon_arbiter: RTL and testbench

AVALON_ARBITER -- requirements
Module: avalon_arbiter

---
 rtl/avalon_arb_pkg.sv | 14 +
 rtl/rr_picker.sv | 21 ++
 rtl/avalon_arbiter.sv | 120 ++++++++++++
 tb/tb_avalon_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_arb_pkg.sv
// Shared types and sizes for the two-master Avalon arbiter.
package avalon_arb_pkg;

    localparam int unsigned NUM_MASTERS = 2;
    localparam int unsigned ADDR_W      = 2;
    localparam int unsigned DATA_W      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner between two requesters; a tie goes to the master not granted last.
module rr_picker
    import avalon_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   last_grant,
    output logic                   winner,
    output logic                   any_req
);

    always_comb begin
        any_req = |req;
        winner  = 1'b0;
        if (&req) begin
            winner = ~last_grant;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/avalon_arbiter.sv
// Two-master arbiter in front of a single Avalon peripheral with 1-cycle read latency.
module avalon_arbiter
    import avalon_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              m0Read,
    input  logic              m1Read,
    input  logic              m0Write,
    input  logic              m1Write,
    input  logic [ADDR_W-1:0] m0Address,
    input  logic [ADDR_W-1:0] m1Address,
    input  logic [DATA_W-1:0] m0DataIn,
    input  logic [DATA_W-1:0] m1DataIn,
    input  logic              m0Lock,
    input  logic              m1Lock,
    output logic              m0WaitRequest,
    output logic              m1WaitRequest,
    output logic              m0ReadValid,
    output logic              m1ReadValid,
    output logic [DATA_W-1:0] m0DataOut,
    output logic [DATA_W-1:0] m1DataOut,
    output logic              sRead,
    output logic              sWrite,
    output logic [ADDR_W-1:0] sAddress,
    output logic [DATA_W-1:0] sDataIn,
    input  logic              sReadValid,
    input  logic [DATA_W-1:0] sDataOut
);

    state_t                 state;
    logic                   last_grant;
    logic                   read_owner;
    logic                   read_pending;
    logic [NUM_MASTERS-1:0] req;
    logic                   winner;
    logic                   any_req;

    logic                   busy;
    logic                   cur;
    logic                   cur_read;
    logic                   cur_write;
    logic                   cur_lock;
    logic [ADDR_W-1:0]      cur_addr;
    logic [DATA_W-1:0]      cur_data;
    logic                   accept;
    logic                   accept_read;
    logic                   read_valid;

    assign req = {m1Read | m1Write, m0Read | m0Write};

    rr_picker u_picker (
        .req        (req),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    // Selected master's command while a grant is held
    assign busy        = (state == BUSY0) || (state == BUSY1);
    assign cur         = (state == BUSY1);
    assign cur_read    = cur ? m1Read    : m0Read;
    assign cur_write   = cur ? m1Write   : m0Write;
    assign cur_lock    = cur ? m1Lock    : m0Lock;
    assign cur_addr    = cur ? m1Address : m0Address;
    assign cur_data    = cur ? m1DataIn  : m0DataIn;
    assign accept      = busy & (cur_read | cur_write);
    assign accept_read = accept & cur_read & ~cur_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            read_owner   <= 1'b0;
            read_pending <= 1'b0;
        end else begin
            read_pending <= accept_read;
            if (accept_read) begin
                read_owner <= cur;
            end
            if (accept) begin
                last_grant <= cur;
            end
            case (state)
                IDLE:         if (any_req) state <= winner ? BUSY1 : BUSY0;
                BUSY0, BUSY1: state <= (accept && cur_lock) ? state : IDLE;
                default:      state <= IDLE;
            endcase
        end
    end

    // Peripheral side mirrors the granted master; a write wins over a simultaneous read
    always_comb begin
        sRead         = 1'b0;
        sWrite        = 1'b0;
        sAddress      = '0;
        sDataIn       = '0;
        m0WaitRequest = 1'b1;
        m1WaitRequest = 1'b1;
        if (busy) begin
            sRead    = cur_read & ~cur_write;
            sWrite   = cur_write;
            sAddress = cur_addr;
            sDataIn  = cur_data;
            if (cur) begin
                m1WaitRequest = 1'b0;
            end else begin
                m0WaitRequest = 1'b0;
            end
        end
    end

    // Responses only count for a read this arbiter actually issued before any reset
    assign read_valid  = sReadValid & read_pending & ~reset;
    assign m0ReadValid = read_valid & ~read_owner;
    assign m1ReadValid = read_valid & read_owner;
    assign m0DataOut   = m0ReadValid ? sDataOut : '0;
    assign m1DataOut   = m1ReadValid ? sDataOut : '0;

endmodule

// File: tb/tb_avalon_arbiter.sv
// Bench for avalon_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_avalon_arbiter;

    logic        clk;
    logic        reset;
    logic        m0Read, m1Read, m0Write, m1Write, m0Lock, m1Lock;
    logic [1:0]  m0Address, m1Address;
    logic [31:0] m0DataIn, m1DataIn;
    logic        m0WaitRequest, m1WaitRequest, m0ReadValid, m1ReadValid;
    logic [31:0] m0DataOut, m1DataOut;
    logic        sRead, sWrite, sReadValid;
    logic [1:0]  sAddress;
    logic [31:0] sDataIn, sDataOut;

    int tests_run;
    int tests_failed;

    // Model: granted master (-1 = none), last served master, pending read owner and its data
    int          mg, mlg, mpend;
    logic [31:0] mpend_data;
    logic [31:0] mmem [4];
    logic [31:0] pmem [4];

    logic [37:0] exp_cmd, act_cmd;
    logic [65:0] exp_rsp, act_rsp;

    avalon_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .m0Read        (m0Read),
        .m1Read        (m1Read),
        .m0Write       (m0Write),
        .m1Write       (m1Write),
        .m0Address     (m0Address),
        .m1Address     (m1Address),
        .m0DataIn      (m0DataIn),
        .m1DataIn      (m1DataIn),
        .m0Lock        (m0Lock),
        .m1Lock        (m1Lock),
        .m0WaitRequest (m0WaitRequest),
        .m1WaitRequest (m1WaitRequest),
        .m0ReadValid   (m0ReadValid),
        .m1ReadValid   (m1ReadValid),
        .m0DataOut     (m0DataOut),
        .m1DataOut     (m1DataOut),
        .sRead         (sRead),
        .sWrite        (sWrite),
        .sAddress      (sAddress),
        .sDataIn       (sDataIn),
        .sReadValid    (sReadValid),
        .sDataOut      (sDataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        m0Read = 0; m1Read = 0; m0Write = 0; m1Write = 0; m0Lock = 0; m1Lock = 0;
        m0Address = 0; m1Address = 0; m0DataIn = 0; m1DataIn = 0;
    endtask

    task automatic model_reset();
        mg = -1; mlg = 1; mpend = -1; mpend_data = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        clear_inputs();
        sReadValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One bus cycle: sample outputs at negedge, predict, then act as the peripheral after the edge
    task automatic tick();
        logic [1:0]  rd, wr, lk;
        logic [1:0]  ad [2];
        logic [31:0] dt [2];
        logic        p_rd, p_wr;
        logic [1:0]  p_a;
        logic [31:0] p_d;
        int          x, mg_n, pend_n;
        logic [31:0] pend_data_n;
        @(negedge clk);
        rd = {m1Read, m0Read};
        wr = {m1Write, m0Write};
        lk = {m1Lock, m0Lock};
        ad[0] = m0Address; ad[1] = m1Address;
        dt[0] = m0DataIn;  dt[1] = m1DataIn;
        act_cmd = {m0WaitRequest, m1WaitRequest, sRead, sWrite, sAddress, sDataIn};
        act_rsp = {m0ReadValid, m1ReadValid, m0DataOut, m1DataOut};
        p_rd = sRead; p_wr = sWrite; p_a = sAddress; p_d = sDataIn;

        if (mg < 0) begin
            exp_cmd = {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0};
        end else begin
            x = mg;
            exp_cmd = {1'(x != 0), 1'(x != 1), rd[x] & ~wr[x], wr[x], ad[x], dt[x]};
        end
        if (mpend < 0) exp_rsp = 66'd0;
        else exp_rsp = {1'(mpend == 0), 1'(mpend == 1),
                        (mpend == 0) ? mpend_data : 32'd0,
                        (mpend == 1) ? mpend_data : 32'd0};

        pend_n = -1;
        pend_data_n = 32'd0;
        if (mg < 0) begin
            if ((rd[0] | wr[0]) && (rd[1] | wr[1])) mg_n = 1 - mlg;
            else if (rd[1] | wr[1]) mg_n = 1;
            else if (rd[0] | wr[0]) mg_n = 0;
            else mg_n = -1;
        end else begin
            x = mg;
            if (rd[x] | wr[x]) begin
                mlg = x;
                if (wr[x]) mmem[ad[x]] = dt[x];
                else begin
                    pend_n = x;
                    pend_data_n = mmem[ad[x]];
                end
                mg_n = lk[x] ? x : -1;
            end else begin
                mg_n = -1;
            end
        end

        @(posedge clk); #1;
        sReadValid = p_rd;
        sDataOut   = p_rd ? pmem[p_a] : $urandom();
        if (p_wr) pmem[p_a] = p_d;
        mg = mg_n;
        mpend = pend_n;
        mpend_data = pend_data_n;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        m0Read = 1; m1Write = 1; sReadValid = 1; sDataOut = 32'hDEADBEEF;
        @(negedge clk);
        tests_run++;
        if ({m0WaitRequest, m1WaitRequest, sRead, sWrite} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL reset_cmd: got %b want 1100", {m0WaitRequest, m1WaitRequest, sRead, sWrite});
        end
        tests_run++;
        if ({m0ReadValid, m1ReadValid, m0DataOut, m1DataOut} !== 66'd0) begin
            tests_failed++;
            $display("FAIL reset_rsp: got %h want 0", {m0ReadValid, m1ReadValid, m0DataOut, m1DataOut});
        end
        @(posedge clk); #1;
        clear_inputs();
        sReadValid = 0;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single_write();
        do_reset();
        m0Write = 1; m0Address = 2'd0; m0DataIn = 32'h1234;
        tick();
        tests_run++;
        if (act_cmd !== {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL write_idle: got %h want %h", act_cmd, {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0});
        end
        tick();
        tests_run++;
        if (act_cmd !== {1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h1234}) begin
            tests_failed++;
            $display("FAIL write_issue: got %h want %h", act_cmd, {1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h1234});
        end
        m0Write = 0;
        tick();
        tests_run++;
        if (act_cmd[37:34] !== 4'b1100) begin
            tests_failed++;
            $display("FAIL write_after: got %b want 1100", act_cmd[37:34]);
        end
    endtask

    task automatic test_simultaneous_read();
        do_reset();
        m0Read = 1; m0Address = 2'd1; m1Read = 1; m1Address = 2'd2;
        tick();
        tick();
        tests_run++;
        if (act_cmd !== {1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 32'd0}) begin
            tests_failed++;
            $display("FAIL dual_m0_issue: got %h want %h", act_cmd, {1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 32'd0});
        end
        m0Read = 0;
        tick();
        tests_run++;
        if (act_rsp !== {1'b1, 1'b0, 32'hA5A5_0001, 32'd0}) begin
            tests_failed++;
            $display("FAIL dual_m0_data: got %h want %h", act_rsp, {1'b1, 1'b0, 32'hA5A5_0001, 32'd0});
        end
        tick();
        tests_run++;
        if (act_cmd !== {1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'd0}) begin
            tests_failed++;
            $display("FAIL dual_m1_issue: got %h want %h", act_cmd, {1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'd0});
        end
        m1Read = 0;
        tick();
        tests_run++;
        if (act_rsp !== {1'b0, 1'b1, 32'd0, 32'hA5A5_0002}) begin
            tests_failed++;
            $display("FAIL dual_m1_data: got %h want %h", act_rsp, {1'b0, 1'b1, 32'd0, 32'hA5A5_0002});
        end
    endtask

    task automatic test_alternate();
        logic [1:0] want_w, want_v;
        do_reset();
        m0Read = 1; m0Address = 2'd3; m1Read = 1; m1Address = 2'd1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i % 2 == 0) want_w = 2'b11;
            else want_w = (((i >> 1) & 1) == 0) ? 2'b01 : 2'b10;
            if (i >= 2 && i % 2 == 0) want_v = ((((i - 2) >> 1) & 1) == 0) ? 2'b10 : 2'b01;
            else want_v = 2'b00;
            tests_run++;
            if (act_cmd[37:36] !== want_w || act_rsp[65:64] !== want_v) begin
                tests_failed++;
                $display("FAIL alternate cycle %0d: got wait %b valid %b want wait %b valid %b",
                         i, act_cmd[37:36], act_rsp[65:64], want_w, want_v);
            end
        end
    endtask

    task automatic test_lock();
        do_reset();
        m1Read = 1; m1Lock = 1; m1Address = 2'd3;
        tick();
        m0Read = 1; m0Address = 2'd2;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) m1Lock = 0;
            tick();
            tests_run++;
            if (act_cmd[37:34] !== 4'b1010) begin
                tests_failed++;
                $display("FAIL lock_read %0d: got %b want 1010", k, act_cmd[37:34]);
            end
            if (k >= 1) begin
                tests_run++;
                if (act_rsp !== {1'b0, 1'b1, 32'd0, 32'hA5A5_0003}) begin
                    tests_failed++;
                    $display("FAIL lock_data %0d: got %h want %h", k, act_rsp, {1'b0, 1'b1, 32'd0, 32'hA5A5_0003});
                end
            end
        end
        m1Read = 0;
        tick();
        tests_run++;
        if (act_cmd[37:36] !== 2'b11 || act_rsp[65:64] !== 2'b01) begin
            tests_failed++;
            $display("FAIL lock_release: got wait %b valid %b want wait 11 valid 01", act_cmd[37:36], act_rsp[65:64]);
        end
        tick();
        tests_run++;
        if (act_cmd[37:34] !== 4'b0110) begin
            tests_failed++;
            $display("FAIL lock_m0_grant: got %b want 0110", act_cmd[37:34]);
        end
        m0Read = 0;
        tick();
        tests_run++;
        if (act_rsp !== {1'b1, 1'b0, 32'hA5A5_0002, 32'd0}) begin
            tests_failed++;
            $display("FAIL lock_m0_data: got %h want %h", act_rsp, {1'b1, 1'b0, 32'hA5A5_0002, 32'd0});
        end
    endtask

    task automatic test_read_write_both();
        do_reset();
        m0Read = 1; m0Write = 1; m0Address = 2'd1; m0DataIn = 32'hCAFE_0001;
        tick();
        tick();
        tests_run++;
        if (act_cmd !== {1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'hCAFE_0001}) begin
            tests_failed++;
            $display("FAIL rw_issue: got %h want %h", act_cmd, {1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'hCAFE_0001});
        end
        clear_inputs();
        tick();
        tests_run++;
        if (act_rsp !== 66'd0) begin
            tests_failed++;
            $display("FAIL rw_no_valid: got %h want 0", act_rsp);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0Read = 1; m0Address = 2'd2;
        tick();
        reset = 1'b1;
        #1;
        tests_run++;
        if ({m0WaitRequest, m1WaitRequest, sRead, sWrite} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL midreset_cmd: got %b want 1100", {m0WaitRequest, m1WaitRequest, sRead, sWrite});
        end
        sReadValid = 1; sDataOut = 32'hBAD0_BAD0;
        #1;
        tests_run++;
        if ({m0ReadValid, m1ReadValid, m0DataOut, m1DataOut} !== 66'd0) begin
            tests_failed++;
            $display("FAIL midreset_rsp: got %h want 0", {m0ReadValid, m1ReadValid, m0DataOut, m1DataOut});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m0Read = 0;
        model_reset();
        @(negedge clk);
        tests_run++;
        if ({m0ReadValid, m1ReadValid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL midreset_stale: got %b want 00", {m0ReadValid, m1ReadValid});
        end
        @(posedge clk); #1;
        sReadValid = 0;
        m0Read = 1; m1Read = 1;
        tick();
        tick();
        tests_run++;
        if (act_cmd[37:36] !== 2'b01) begin
            tests_failed++;
            $display("FAIL midreset_tie: got %b want 01", act_cmd[37:36]);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            m0Read    = 1'($urandom_range(0, 1));
            m1Read    = 1'($urandom_range(0, 1));
            m0Write   = ($urandom_range(0, 3) == 0);
            m1Write   = ($urandom_range(0, 3) == 0);
            m0Lock    = ($urandom_range(0, 3) == 0);
            m1Lock    = ($urandom_range(0, 3) == 0);
            m0Address = 2'($urandom());
            m1Address = 2'($urandom());
            m0DataIn  = $urandom();
            m1DataIn  = $urandom();
            tick();
            tests_run++;
            if (act_cmd !== exp_cmd) begin
                tests_failed++;
                $display("FAIL random_cmd cycle %0d: got %h want %h", i, act_cmd, exp_cmd);
            end
            tests_run++;
            if (act_rsp !== exp_rsp) begin
                tests_failed++;
                $display("FAIL random_rsp cycle %0d: got %h want %h", i, act_rsp, exp_rsp);
            end
        end
        clear_inputs();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b0;
        sReadValid = 1'b0;
        sDataOut = 32'd0;
        clear_inputs();
        model_reset();
        for (int i = 0; i < 4; i++) begin
            mmem[i] = 32'hA5A5_0000 + 32'(i);
            pmem[i] = 32'hA5A5_0000 + 32'(i);
        end
        test_reset();
        test_single_write();
        test_simultaneous_read();
        test_alternate();
        test_lock();
        test_read_write_both();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
